// File: rtl/octal_key_debouncer_if.sv
// Key-line bundle between the raw keypad and the debouncer, plus the cleaned
// outputs that feed the octal-to-binary encoder.
interface octal_key_debouncer_if;
    logic [7:0] key_raw;
    logic [7:0] onehot_out;
    logic       key_valid;
    logic       key_held;
    logic       multi_err;

    modport master (
        output key_raw,
        input  onehot_out,
        input  key_valid,
        input  key_held,
        input  multi_err
    );

    modport slave (
        input  key_raw,
        output onehot_out,
        output key_valid,
        output key_held,
        output multi_err
    );
endinterface

// File: rtl/octal_key_debouncer.sv
// Synchronises and debounces eight raw key lines, accepting a key only when a
// single line is stably active; emits a registered one-hot code and strobes.
module octal_key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    octal_key_debouncer_if.slave  keys
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        PRESSED  = 3'd2,
        RELEASE  = 3'd3,
        LOCKOUT  = 3'd4
    } state_t;

    function automatic logic is_one_hot(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

    logic [7:0]       sync_p0;
    logic [7:0]       sync_p1;
    state_t           state;
    state_t           state_nxt;
    logic [7:0]       cap;
    logic [7:0]       cap_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             valid_nxt;
    logic             err_nxt;
    logic             held_nxt;

    // Stage p0/p1: two-flop synchroniser for the asynchronous key lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 8'h00;
            sync_p1 <= 8'h00;
        end else begin
            sync_p0 <= keys.key_raw;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cap             <= 8'h00;
            cnt             <= '0;
            keys.onehot_out <= 8'h00;
            keys.key_valid  <= 1'b0;
            keys.key_held   <= 1'b0;
            keys.multi_err  <= 1'b0;
        end else begin
            state           <= state_nxt;
            cap             <= cap_nxt;
            cnt             <= cnt_nxt;
            keys.onehot_out <= held_nxt ? cap_nxt : 8'h00;
            keys.key_valid  <= valid_nxt;
            keys.key_held   <= held_nxt;
            keys.multi_err  <= err_nxt;
        end
    end

    // Any change of the synchronised pattern restarts the stability count.
    always_comb begin
        state_nxt = state;
        cap_nxt   = cap;
        cnt_nxt   = cnt;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (sync_p1 != 8'h00) begin
                    cap_nxt   = sync_p1;
                    cnt_nxt   = '0;
                    state_nxt = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (sync_p1 == 8'h00) begin
                    state_nxt = IDLE;
                end else if (sync_p1 != cap) begin
                    cap_nxt = sync_p1;
                    cnt_nxt = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end else if (is_one_hot(cap)) begin
                    state_nxt = PRESSED;
                    valid_nxt = 1'b1;
                end else begin
                    err_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = LOCKOUT;
                end
            end
            PRESSED: begin
                if (sync_p1 != cap) begin
                    cnt_nxt   = '0;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (sync_p1 == cap) begin
                    state_nxt = PRESSED;
                end else if (sync_p1 != 8'h00) begin
                    cnt_nxt = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            LOCKOUT: begin
                // A chord must fully release before any new key is considered.
                if (sync_p1 != 8'h00) begin
                    cnt_nxt = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign held_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE);
endmodule

// File: tb/tb_octal_key_debouncer.sv
// Directed and randomized bench for octal_key_debouncer, compared every cycle
// against a run-length reference model of the debounce rules.
module tb_octal_key_debouncer;
    localparam int D = 4;

    logic clk;
    logic rst_n;
    octal_key_debouncer_if kif();

    octal_key_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .keys  (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;
    int n_valid;
    int n_err;
    int n_active;

    typedef enum {M_FREE, M_HELD, M_LOCK} mode_t;
    mode_t      mode;
    logic [7:0] sp0, sp1;
    logic [7:0] run_val;
    int         run_len;
    logic [7:0] last_nz;
    logic [7:0] key;
    logic [7:0] exp_onehot;
    logic       exp_valid, exp_held, exp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mode = M_FREE; sp0 = 8'h00; sp1 = 8'h00;
        run_val = 8'h00; run_len = 0; last_nz = 8'h00; key = 8'h00;
        exp_onehot = 8'h00; exp_valid = 1'b0; exp_held = 1'b0; exp_err = 1'b0;
    endtask

    // s is the synchronised pattern seen at this clock edge.
    task automatic model_edge(input logic [7:0] s);
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (s == run_val) run_len++;
        else begin
            run_val = s;
            run_len = 1;
        end
        case (mode)
            M_FREE: if (s != 8'h00 && run_len == D + 1) begin
                if ($countones(s) == 1) begin
                    mode = M_HELD; key = s; exp_valid = 1'b1;
                end else begin
                    mode = M_LOCK; exp_err = 1'b1;
                end
            end
            M_HELD: if (s == 8'h00 && run_len == ((last_nz == key) ? D + 1 : D)) mode = M_FREE;
            M_LOCK: if (s == 8'h00 && run_len == D) mode = M_FREE;
            default: mode = M_FREE;
        endcase
        if (s != 8'h00) last_nz = s;
        exp_held   = (mode == M_HELD);
        exp_onehot = exp_held ? key : 8'h00;
    endtask

    task automatic step(input logic [7:0] raw);
        @(negedge clk);
        kif.key_raw = raw;
        @(posedge clk);
        model_edge(sp1);
        sp1 = sp0;
        sp0 = raw;
        #1;
        check("onehot_out", kif.onehot_out, exp_onehot);
        check("key_valid", kif.key_valid, exp_valid);
        check("key_held", kif.key_held, exp_held);
        check("multi_err", kif.multi_err, exp_err);
        check("strobe_excl", kif.key_valid & kif.multi_err, 0);
        check("onehot_legal", ($countones(kif.onehot_out) <= 1), 1);
        if (kif.key_valid) n_valid++;
        if (kif.multi_err) n_err++;
        if (kif.onehot_out != 8'h00 || kif.key_valid || kif.multi_err || kif.key_held) n_active++;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(8'h00);
    endtask

    initial begin
        int first;
        logic [7:0] v;
        tests = 0; fails = 0;
        n_valid = 0; n_err = 0; n_active = 0;
        rst_n = 1'b0;
        kif.key_raw = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_onehot", kif.onehot_out, 8'h00);
        check("rst_valid", kif.key_valid, 0);
        check("rst_held", kif.key_held, 0);
        check("rst_err", kif.multi_err, 0);
        rst_n = 1'b1;
        idle_steps(3);

        // Clean press and release
        n_valid = 0; first = -1;
        for (int i = 0; i < 20; i++) begin
            step(8'h04);
            if (kif.key_valid && first < 0) first = i;
        end
        check("press_latency", first, D + 2);
        check("press_count", n_valid, 1);
        check("press_onehot", kif.onehot_out, 8'h04);
        first = -1;
        for (int i = 0; i < 10; i++) begin
            step(8'h00);
            if (kif.onehot_out == 8'h00 && first < 0) first = i;
        end
        check("release_latency", first, D + 2);

        // Bouncy press
        n_valid = 0; first = -1;
        step(8'h10); step(8'h00); step(8'h10); step(8'h00);
        for (int i = 0; i < 10; i++) begin
            step(8'h10);
            if (kif.key_valid && first < 0) first = i;
        end
        check("bounce_latency", first, D + 2);
        check("bounce_count", n_valid, 1);
        check("bounce_onehot", kif.onehot_out, 8'h10);
        idle_steps(10);

        // Chord then partial release
        n_valid = 0; n_err = 0;
        for (int i = 0; i < 8; i++) step(8'h05);
        check("chord_err", n_err, 1);
        check("chord_valid", n_valid, 0);
        for (int i = 0; i < 8; i++) step(8'h01);
        check("chord_partial_onehot", kif.onehot_out, 8'h00);
        check("chord_partial_valid", n_valid, 0);
        idle_steps(10);

        // Short glitch
        n_active = 0;
        for (int i = 0; i < D - 1; i++) step(8'h80);
        idle_steps(8);
        check("glitch_activity", n_active, 0);

        // Release bounce
        n_valid = 0;
        for (int i = 0; i < 8; i++) step(8'h02);
        step(8'h00); step(8'h00);
        for (int i = 0; i < 6; i++) step(8'h02);
        check("relbounce_count", n_valid, 1);
        check("relbounce_onehot", kif.onehot_out, 8'h02);
        idle_steps(10);

        // Reset while pressed, key still held afterwards
        for (int i = 0; i < 8; i++) step(8'h20);
        check("pre_reset_onehot", kif.onehot_out, 8'h20);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_onehot", kif.onehot_out, 8'h00);
        check("midrst_valid", kif.key_valid, 0);
        check("midrst_held", kif.key_held, 0);
        check("midrst_err", kif.multi_err, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_valid = 0; first = -1;
        for (int i = 0; i < 10; i++) begin
            step(8'h20);
            if (kif.key_valid && first < 0) first = i;
        end
        check("postrst_latency", first, D + 2);
        check("postrst_count", n_valid, 1);
        idle_steps(10);

        // Randomized segments of held patterns
        for (int e = 0; e < 220; e++) begin
            int len;
            int sel;
            len = $urandom_range(1, 8);
            sel = $urandom_range(0, 99);
            if (sel < 45) v = 8'h00;
            else if (sel < 85) v = 8'h01 << $urandom_range(0, 7);
            else v = 8'($urandom);
            for (int k = 0; k < len; k++) step(v);
        end
        idle_steps(12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/octal_key_debouncer.md
# octal_key_debouncer

Cleans up eight raw, bouncy, asynchronous key lines and presents a stable one-hot vector to the octal-to-binary encoder stage. It synchronises the lines, debounces press and release, and accepts a key only when exactly one line is stably active. It emits a single-cycle strobe per accepted press. The encoder stage consumes `onehot_out` directly; `key_valid` qualifies the encoded code downstream.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a press or a release. Legal range is 2..65535. Counter width is `$clog2(DEBOUNCE_CYCLES)`.
- `clk` input, 1 bit: single clock; all logic on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous assert, active-low.
- `key_raw` input, 8 bits: raw key lines, active-high, asynchronous to `clk`, may bounce.
- `onehot_out` output, 8 bits: accepted key as a one-hot vector; 0 when no key is accepted.
- `key_valid` output, 1 bit: one-cycle pulse when a press is accepted.
- `key_held` output, 1 bit: high while the accepted key remains held (states PRESSED and RELEASE).
- `multi_err` output, 1 bit: one-cycle pulse when a stable multi-key pattern is rejected.

## Operation
- **Synchroniser:** two-flop synchroniser on all 8 lines, giving `sync`. Both flops reset to 0.
- **State machine:** states IDLE, DEBOUNCE, PRESSED, RELEASE, LOCKOUT. Internal `cap[7:0]` holds the candidate pattern; `cnt` is the stability counter.
- **IDLE:** `onehot_out`=0. If `sync`≠0: `cap`←`sync`, `cnt`←0, go to DEBOUNCE.
- **DEBOUNCE:**
  - If `sync`=0: go to IDLE.
  - Else if `sync`≠`cap`: `cap`←`sync`, `cnt`←0.
  - Else if `cnt`≠`DEBOUNCE_CYCLES`-1: `cnt`++.
  - Else, if `cap` has exactly one bit set: go to PRESSED, `onehot_out`←`cap`, pulse `key_valid`.
  - Else (two or more bits set): pulse `multi_err`, `cnt`←0, go to LOCKOUT.
- **PRESSED:** `onehot_out` holds `cap`. If `sync`≠`cap` (release, bounce, or an extra key added): `cnt`←0, go to RELEASE.
- **RELEASE:**
  - `onehot_out` still holds `cap`.
  - If `sync`=`cap`: return to PRESSED with no new `key_valid`.
  - If `sync`≠0 and `sync`≠`cap`: `cnt`←0, stay.
  - If `sync`=0, count; at `cnt`=`DEBOUNCE_CYCLES`-1 with `sync`=0, go to IDLE and `onehot_out`←0.
- **LOCKOUT:** `onehot_out`=0. Requires `sync`=0 for `DEBOUNCE_CYCLES` consecutive cycles before returning to IDLE; any nonzero `sync` resets `cnt`. Prevents accepting a key while partially releasing a chord.
- **One-hot guarantee:** `onehot_out` is always 0 or exactly one-hot, so the encoder never sees an illegal pattern.
- **Strobe rules:** `key_valid` and `multi_err` are never high together. Each fires at most once per press episode.
- **Reset mid-operation:** immediately aborts to IDLE; no pulse is generated on reset release.

## Timing
- **Reset values:** `onehot_out`=8'h00, `key_valid`=0, `key_held`=0, `multi_err`=0, state=IDLE, `cnt`=0, `cap`=0.
- **Registered outputs:** all outputs are registered; there is no combinational path from `key_raw`.
- **Press latency:** `key_raw` stable from edge N → DEBOUNCE entered at edge N+2 → `key_valid`/`onehot_out` update at edge N+2+`DEBOUNCE_CYCLES`. That is D+2 cycles; 18 at the default.
- **Release latency:** `key_raw`=0 stable from edge M → `onehot_out` clears at edge M+2+`DEBOUNCE_CYCLES`.
- **Glitch rejection:** any bounce restarts the count, so a glitch shorter than `DEBOUNCE_CYCLES` cycles produces no output change.
- **Pulse width:** `key_valid` and `multi_err` are high for exactly one cycle.
- **`key_held`:** asserts in the same cycle as `key_valid` and deasserts in the same cycle `onehot_out` clears.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Clean press:** `key_raw`=8'h04 held from edge 0 → `key_valid` pulse and `onehot_out`=8'h04 after edge 6. Release at edge 20 → `onehot_out`=0 after edge 26.
- **Bouncy press:** `key_raw` toggles 8'h10/0 for 3 cycles, then holds 8'h10 → exactly one `key_valid`, `onehot_out`=8'h10 six cycles after the last toggle.
- **Chord:** `key_raw`=8'h05 held → `multi_err` pulse after 6 cycles, no `key_valid`, `onehot_out` stays 0. Then drop to 8'h01 → still 0 (LOCKOUT) until all keys are released for 4 cycles.
- **Short glitch:** a 3-cycle `key_raw`=8'h80 pulse → no output activity at all.
- **Release bounce:** while 8'h02 is accepted, drop to 0 for 2 cycles, then back to 8'h02 → `onehot_out` stays 8'h02, no second `key_valid`.
- **Reset mid-press:** assert `rst_n`=0 asynchronously while in PRESSED → all outputs 0 immediately. Release reset with the key still held → new `key_valid` D+2 cycles later.
